// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared types for the dual-slot core's memory-access stage.
//   mem_op_t      : lower-slot memory operation encoding (raw value 3 = none)
//   mem_state_t   : data-memory port FSM states
//   wb_bundle_t   : the bundle handed to writeback
//   WB_BUBBLE     : all-zero writeback bundle (no register write)
//   decode_mem_op : folds the unused encoding onto NONE
// -----------------------------------------------------------------------------
package core_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [63:0] inst;
    logic [31:0] u_tdata;
    logic [4:0]  u_rt;
    logic        u_rt_flag;
    logic [31:0] l_tdata;
    logic [4:0]  l_rt;
    logic        l_rt_flag;
  } wb_bundle_t;

  localparam wb_bundle_t WB_BUBBLE = '0;

  function automatic mem_op_t decode_mem_op(input logic [1:0] raw);
    case (raw)
      2'd1:    return LOAD;
      2'd2:    return STORE;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/dmem_port.sv
// -----------------------------------------------------------------------------
// dmem_port
// Data-memory handshake for lower-slot loads and stores. Owns the request
// registers and the IDLE/REQ/WAIT state machine.
//   clk, rst        : clock, synchronous active-high reset
//   start           : launch a request (only honoured in IDLE)
//   start_we        : 1 = store
//   start_addr      : word-aligned byte address
//   start_wdata     : store data
//   busy            : state != IDLE (registered decode, drives mem_stall)
//   dmem_req/we/addr/wdata : request towards memory, all registered
//   dmem_ready      : memory accepts the request this cycle
//   dmem_rvalid     : load data valid (only honoured in WAIT)
//   dmem_rdata      : load data
//   done            : operation completes at the coming edge
//   done_load       : the completing operation is a load
//   rdata           : load data to be written back
// -----------------------------------------------------------------------------
module dmem_port
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        start_we,
  input  logic [31:0] start_addr,
  input  logic [31:0] start_wdata,
  output logic        busy,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        done,
  output logic        done_load,
  output logic [31:0] rdata
);

  mem_state_t  state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    done      = 1'b0;
    done_load = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = start_we;
          addr_d  = start_addr;
          wdata_d = start_wdata;
        end
      end
      REQ: begin
        // Request fields stay frozen until the memory takes them.
        if (dmem_ready) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          if (we_q) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // rvalid is only meaningful here; anywhere else it is dropped.
        if (dmem_rvalid) begin
          done      = 1'b1;
          done_load = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign rdata      = dmem_rdata;

endmodule

// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
// Pipeline stage between execute and writeback. Non-memory bundles reach
// writeback one cycle later; lower-slot loads/stores go through dmem_port,
// during which upstream is stalled and writeback sees bubbles.
//   clk, rst                  : clock, synchronous active-high reset
//   inst                      : execute bundle (upper [63:32], lower [31:0])
//   u_tdata/u_rt/u_rt_flag    : upper-slot result
//   l_tdata/l_rt/l_rt_flag    : lower-slot result (l_tdata = address for mem ops)
//   l_sdata                   : store data
//   l_mem_op                  : 0 none, 1 load, 2 store, 3 none
//   mem_stall                 : upstream must hold its inputs
//   dmem_*                    : data-memory request / response handshake
//   wb_*                      : registered bundle towards writeback
// -----------------------------------------------------------------------------
module memory_access
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] inst,
  input  logic [31:0] u_tdata,
  input  logic [4:0]  u_rt,
  input  logic        u_rt_flag,
  input  logic [31:0] l_tdata,
  input  logic [31:0] l_sdata,
  input  logic [4:0]  l_rt,
  input  logic        l_rt_flag,
  input  logic [1:0]  l_mem_op,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [63:0] wb_inst,
  output logic [31:0] wb_u_tdata,
  output logic [4:0]  wb_u_rt,
  output logic        wb_u_rt_flag,
  output logic [31:0] wb_l_tdata,
  output logic [4:0]  wb_l_rt,
  output logic        wb_l_rt_flag
);

  wb_bundle_t in_bundle;
  wb_bundle_t hold_q, hold_d;
  wb_bundle_t wb_q, wb_d;
  mem_op_t    op;
  logic       busy;
  logic       start;
  logic       done;
  logic       done_load;
  logic [31:0] rdata;

  assign in_bundle = '{
    inst:      inst,
    u_tdata:   u_tdata,
    u_rt:      u_rt,
    u_rt_flag: u_rt_flag,
    l_tdata:   l_tdata,
    l_rt:      l_rt,
    l_rt_flag: l_rt_flag
  };

  assign op    = decode_mem_op(l_mem_op);
  assign start = !busy && (op != NONE);

  dmem_port u_dmem_port (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_we    (op == STORE),
    .start_addr  ({l_tdata[31:2], 2'b00}),
    .start_wdata (l_sdata),
    .busy        (busy),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_ready  (dmem_ready),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .done        (done),
    .done_load   (done_load),
    .rdata       (rdata)
  );

  always_comb begin
    hold_d = hold_q;
    wb_d   = WB_BUBBLE;

    if (!busy) begin
      if (start) begin
        // The whole bundle waits here so the upper slot reaches writeback
        // together with the lower result.
        hold_d = in_bundle;
      end else begin
        wb_d = in_bundle;
      end
    end else if (done) begin
      wb_d = hold_q;
      if (done_load) begin
        wb_d.l_tdata = rdata;
      end else begin
        wb_d.l_rt_flag = 1'b0;
      end
    end
  end

  // NOTE: the hold register is not reset: it is only read after a capture
  // has overwritten it, so a reset would cost logic for no behaviour.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= WB_BUBBLE;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign mem_stall    = busy;
  assign wb_inst      = wb_q.inst;
  assign wb_u_tdata   = wb_q.u_tdata;
  assign wb_u_rt      = wb_q.u_rt;
  assign wb_u_rt_flag = wb_q.u_rt_flag;
  assign wb_l_tdata   = wb_q.l_tdata;
  assign wb_l_rt      = wb_q.l_rt;
  assign wb_l_rt_flag = wb_q.l_rt_flag;

endmodule
